// File: rtl/receive_synchronization_pkg.sv
// Shared definitions for the PCS receive synchronization stage.
// Holds the code-group width, the sync FSM state encoding, the reference
// idle code-groups (K28.5, D16.2) and the comma patterns.
package receive_synchronization_pkg;

    localparam int unsigned CG_WIDTH    = 10;
    localparam int unsigned COMMA_WIDTH = 7;
    localparam int unsigned GOOD_WIDTH  = 2;

    // 13 synchronization states, 4-bit encoding
    typedef enum logic [3:0] {
        ST_LOS  = 4'd0,
        ST_CD1  = 4'd1,
        ST_CD2  = 4'd2,
        ST_CD3  = 4'd3,
        ST_AS1  = 4'd4,
        ST_AS2  = 4'd5,
        ST_SA1  = 4'd6,
        ST_SA2  = 4'd7,
        ST_SA2A = 4'd8,
        ST_SA3  = 4'd9,
        ST_SA3A = 4'd10,
        ST_SA4  = 4'd11,
        ST_SA4A = 4'd12
    } sync_state_e;

    localparam logic [CG_WIDTH-1:0] K28_5_RDN = 10'b0011111010;
    localparam logic [CG_WIDTH-1:0] K28_5_RDP = 10'b1100000101;
    localparam logic [CG_WIDTH-1:0] D16_2_RDN = 10'b0110110101;
    localparam logic [CG_WIDTH-1:0] D16_2_RDP = 10'b1001000101;

    localparam logic [COMMA_WIDTH-1:0] COMMA_RDN = 7'b0011111;
    localparam logic [COMMA_WIDTH-1:0] COMMA_RDP = 7'b1100000;

    // True in the SYNC_ACQUIRED_* family, where sync_status is OK
    function automatic logic is_sync_state(input sync_state_e s);
        case (s)
            ST_SA1, ST_SA2, ST_SA2A, ST_SA3, ST_SA3A, ST_SA4, ST_SA4A: is_sync_state = 1'b1;
            default:                                                   is_sync_state = 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/receive_synchronization_if.sv
// Code-group stream interface between the PMA/loopback source (master) and
// the synchronization stage (slave).
//   rx_code_group   : incoming code-group, bit 9 = bit a
//   signal_detect   : PMA signal present
//   sync_status     : 1 = synchronized
//   rx_even         : phase of the last accepted code-group
//   rx_code_group_o : code-group delayed one cycle
//   rx_cg_invalid   : rx_code_group_o is not a valid 8B/10B code-group
interface receive_synchronization_if;
    import receive_synchronization_pkg::*;

    logic [CG_WIDTH-1:0] rx_code_group;
    logic                signal_detect;
    logic                sync_status;
    logic                rx_even;
    logic [CG_WIDTH-1:0] rx_code_group_o;
    logic                rx_cg_invalid;

    modport master (
        output rx_code_group, signal_detect,
        input  sync_status, rx_even, rx_code_group_o, rx_cg_invalid
    );

    modport slave (
        input  rx_code_group, signal_detect,
        output sync_status, rx_even, rx_code_group_o, rx_cg_invalid
    );
endinterface

// File: rtl/receive_synchronization_cg_checker.sv
// Combinational 8B/10B code-group classifier, disparity-agnostic.
//   code_group_i : 10-bit code-group, bits [9:4] = abcdei, [3:0] = fghj
//   valid_c      : code-group is in the table for either running disparity
//   is_k_c       : code-group is one of the 12 K codes
//   comma_c      : bits [9:3] hold a comma pattern
module sync_cg_checker
    import receive_synchronization_pkg::*;
(
    input  logic [CG_WIDTH-1:0] code_group_i,
    output logic                valid_c,
    output logic                is_k_c,
    output logic                comma_c
);

    logic [5:0] s6;
    logic [3:0] f4;
    logic       ok6_n, ok6_p, flip6, x_ab, x_cd;
    logic       d4_n, d4_p, p7_n, p7_p, a7_n, a7_p;
    logic       four_ok_n, four_ok_p, data_n, data_p;

    assign s6 = code_group_i[9:4];
    assign f4 = code_group_i[3:0];

    // 5b/6b sub-block: which disparity column it belongs to, whether it flips
    // disparity, and whether x selects the alternate D.x.7 encoding
    always_comb begin
        ok6_n = 1'b0;
        ok6_p = 1'b0;
        flip6 = 1'b0;
        x_ab  = 1'b0;
        x_cd  = 1'b0;
        case (s6)
            6'b110001, 6'b101001, 6'b011001, 6'b100101, 6'b010101, 6'b001101,
            6'b110010, 6'b101010, 6'b011010, 6'b100110, 6'b010110, 6'b001110: begin
                ok6_n = 1'b1;
                ok6_p = 1'b1;
            end
            6'b110100, 6'b101100, 6'b011100: begin
                ok6_n = 1'b1;
                ok6_p = 1'b1;
                x_cd  = 1'b1;
            end
            6'b100011, 6'b010011, 6'b001011: begin
                ok6_n = 1'b1;
                ok6_p = 1'b1;
                x_ab  = 1'b1;
            end
            6'b111000: ok6_n = 1'b1;
            6'b000111: ok6_p = 1'b1;
            6'b100111, 6'b011101, 6'b101101, 6'b110101, 6'b111001, 6'b010111, 6'b011011,
            6'b111010, 6'b110011, 6'b110110, 6'b101110, 6'b011110, 6'b101011: begin
                ok6_n = 1'b1;
                flip6 = 1'b1;
            end
            6'b011000, 6'b100010, 6'b010010, 6'b001010, 6'b000110, 6'b101000, 6'b100100,
            6'b000101, 6'b001100, 6'b001001, 6'b010001, 6'b100001, 6'b010100: begin
                ok6_p = 1'b1;
                flip6 = 1'b1;
            end
            default: ;
        endcase
    end

    // 3b/4b sub-block: data columns, primary and alternate .7 encodings
    always_comb begin
        d4_n = 1'b0;
        d4_p = 1'b0;
        p7_n = 1'b0;
        p7_p = 1'b0;
        a7_n = 1'b0;
        a7_p = 1'b0;
        case (f4)
            4'b1011: d4_n = 1'b1;
            4'b0100: d4_p = 1'b1;
            4'b1001, 4'b0101, 4'b1010, 4'b0110: begin
                d4_n = 1'b1;
                d4_p = 1'b1;
            end
            4'b1100: d4_n = 1'b1;
            4'b0011: d4_p = 1'b1;
            4'b1101: d4_n = 1'b1;
            4'b0010: d4_p = 1'b1;
            4'b1110: p7_n = 1'b1;
            4'b0001: p7_p = 1'b1;
            4'b0111: a7_n = 1'b1;
            4'b1000: a7_p = 1'b1;
            default: ;
        endcase
    end

    // A7 replaces P7 only for x=17/18/20 at RD- and x=11/13/14 at RD+
    assign four_ok_n = d4_n | (p7_n & ~x_ab) | (a7_n & x_ab);
    assign four_ok_p = d4_p | (p7_p & ~x_cd) | (a7_p & x_cd);

    // Try both starting disparities; the 4b column follows the 6b outcome
    assign data_n = ok6_n & (flip6 ? four_ok_p : four_ok_n);
    assign data_p = ok6_p & (flip6 ? four_ok_n : four_ok_p);

    // 12 K codes; each RD+ form is the bitwise complement of its RD- form
    always_comb begin
        is_k_c = 1'b0;
        case (code_group_i)
            10'b0011110100, 10'b1100001011,
            10'b0011111001, 10'b1100000110,
            10'b0011110101, 10'b1100001010,
            10'b0011110011, 10'b1100001100,
            10'b0011110010, 10'b1100001101,
            10'b0011111010, 10'b1100000101,
            10'b0011110110, 10'b1100001001,
            10'b0011111000, 10'b1100000111,
            10'b1110101000, 10'b0001010111,
            10'b1101101000, 10'b0010010111,
            10'b1011101000, 10'b0100010111,
            10'b0111101000, 10'b1000010111: is_k_c = 1'b1;
            default:                        is_k_c = 1'b0;
        endcase
    end

    assign valid_c = data_n | data_p | is_k_c;
    assign comma_c = (code_group_i[9:3] == COMMA_RDN) || (code_group_i[9:3] == COMMA_RDP);

endmodule

// File: rtl/receive_synchronization.sv
// PCS receive code-group synchronization (Clause 36 sync state machine).
//   gtx_clk       : one code-group per rising edge
//   mr_main_reset : asynchronous, active-high reset
//   rx_if         : slave side of the code-group stream interface
module receive_synchronization
    import receive_synchronization_pkg::*;
(
    input  logic                      gtx_clk,
    input  logic                      mr_main_reset,
    receive_synchronization_if.slave  rx_if
);

    sync_state_e           state_q, state_d;
    logic                  rx_even_q, rx_even_d;
    logic [GOOD_WIDTH-1:0] good_cgs_q, good_cgs_d;
    logic                  sync_status_q, sync_status_d;
    logic [CG_WIDTH-1:0]   rx_cg_q;
    logic                  rx_cg_invalid_q;

    logic valid, is_k, comma, data, cgbad;

    sync_cg_checker u_checker (
        .code_group_i (rx_if.rx_code_group),
        .valid_c      (valid),
        .is_k_c       (is_k),
        .comma_c      (comma)
    );

    assign data  = valid & ~is_k;
    // A comma arriving while the previous group was even would sit at an odd position
    assign cgbad = ~valid | (comma & rx_even_q);

    // State register and output registers
    always_ff @(posedge gtx_clk or posedge mr_main_reset) begin
        if (mr_main_reset) begin
            state_q         <= ST_LOS;
            rx_even_q       <= 1'b0;
            good_cgs_q      <= '0;
            sync_status_q   <= 1'b0;
            rx_cg_q         <= '0;
            rx_cg_invalid_q <= 1'b0;
        end else begin
            state_q         <= state_d;
            rx_even_q       <= rx_even_d;
            good_cgs_q      <= good_cgs_d;
            sync_status_q   <= sync_status_d;
            rx_cg_q         <= rx_if.rx_code_group;
            rx_cg_invalid_q <= ~valid;
        end
    end

    // Next state plus entry actions of the destination state
    always_comb begin
        state_d       = state_q;
        rx_even_d     = ~rx_even_q;
        good_cgs_d    = good_cgs_q;
        sync_status_d = 1'b0;

        case (state_q)
            ST_LOS:  if (comma) state_d = ST_CD1;
            ST_CD1:  state_d = data ? ST_AS1 : ST_LOS;
            ST_CD2:  state_d = data ? ST_AS2 : ST_LOS;
            ST_CD3:  state_d = data ? ST_SA1 : ST_LOS;
            ST_AS1: begin
                if (cgbad)                    state_d = ST_LOS;
                else if (comma && !rx_even_q) state_d = ST_CD2;
            end
            ST_AS2: begin
                if (cgbad)                    state_d = ST_LOS;
                else if (comma && !rx_even_q) state_d = ST_CD3;
            end
            ST_SA1:  if (cgbad) state_d = ST_SA2;
            ST_SA2:  state_d = cgbad ? ST_SA3 : ST_SA2A;
            ST_SA3:  state_d = cgbad ? ST_SA4 : ST_SA3A;
            ST_SA4:  state_d = cgbad ? ST_LOS : ST_SA4A;
            ST_SA2A: begin
                if (cgbad)                     state_d = ST_SA3;
                else if (good_cgs_q == 2'd3)   state_d = ST_SA1;
            end
            ST_SA3A: begin
                if (cgbad)                     state_d = ST_SA4;
                else if (good_cgs_q == 2'd3)   state_d = ST_SA2;
            end
            ST_SA4A: begin
                if (cgbad)                     state_d = ST_LOS;
                else if (good_cgs_q == 2'd3)   state_d = ST_SA3;
            end
            default: state_d = ST_LOS;
        endcase

        // Loss of signal overrides every other transition
        if (!rx_if.signal_detect) state_d = ST_LOS;

        // Comma detection re-aligns to even; every other state toggles phase
        case (state_d)
            ST_CD1, ST_CD2, ST_CD3: rx_even_d = 1'b1;
            default:                rx_even_d = ~rx_even_q;
        endcase

        case (state_d)
            ST_SA2, ST_SA3, ST_SA4:    good_cgs_d = '0;
            ST_SA2A, ST_SA3A, ST_SA4A: good_cgs_d = good_cgs_q + 2'd1;
            default:                   good_cgs_d = good_cgs_q;
        endcase

        sync_status_d = is_sync_state(state_d);
    end

    assign rx_if.sync_status     = sync_status_q;
    assign rx_if.rx_even         = rx_even_q;
    assign rx_if.rx_code_group_o = rx_cg_q;
    assign rx_if.rx_cg_invalid   = rx_cg_invalid_q;

endmodule

// File: tb/tb_receive_synchronization.sv
// Directed bench for receive_synchronization.
module tb_receive_synchronization;
    import receive_synchronization_pkg::*;

    logic gtx_clk = 1'b0;
    logic mr_main_reset = 1'b1;
    int   n_pass = 0;
    int   n_checks = 0;

    localparam logic [CG_WIDTH-1:0] BAD = 10'b0000000000;

    receive_synchronization_if rx_if ();

    receive_synchronization dut (
        .gtx_clk       (gtx_clk),
        .mr_main_reset (mr_main_reset),
        .rx_if         (rx_if)
    );

    always #5 gtx_clk = ~gtx_clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    // Drive one code-group, let the edge sample it, look just after the edge
    task automatic step(input logic [CG_WIDTH-1:0] cg, input logic sd);
        rx_if.rx_code_group = cg;
        rx_if.signal_detect = sd;
        @(posedge gtx_clk);
        #1;
    endtask

    // Five idle groups (K D K D K) then the sixth (D) must bring sync up
    task automatic acquire(input string tag);
        step(K28_5_RDN, 1'b1);
        step(D16_2_RDP, 1'b1);
        step(K28_5_RDP, 1'b1);
        step(D16_2_RDN, 1'b1);
        step(K28_5_RDN, 1'b1);
        chk({tag, "_sync_after5"}, 32'(rx_if.sync_status), 32'd0);
        step(D16_2_RDP, 1'b1);
        chk({tag, "_sync_after6"}, 32'(rx_if.sync_status), 32'd1);
        chk({tag, "_even_after6"}, 32'(rx_if.rx_even), 32'd0);
    endtask

    logic [CG_WIDTH-1:0] vec_cg  [7];
    logic                vec_inv [7];

    initial begin
        rx_if.rx_code_group = '0;
        rx_if.signal_detect = 1'b0;

        // Reset state
        #12;
        chk("rst_sync", 32'(rx_if.sync_status), 32'd0);
        chk("rst_even", 32'(rx_if.rx_even), 32'd0);
        chk("rst_cgo", 32'(rx_if.rx_code_group_o), 32'd0);
        chk("rst_inv", 32'(rx_if.rx_cg_invalid), 32'd0);
        @(posedge gtx_clk);
        #1;
        mr_main_reset = 1'b0;

        // Comma at odd position in AS1 drops to LOS; full acquisition needed after
        step(K28_5_RDN, 1'b1);
        chk("cd1_even", 32'(rx_if.rx_even), 32'd1);
        chk("cd1_cgo", 32'(rx_if.rx_code_group_o), 32'(K28_5_RDN));
        chk("cd1_inv", 32'(rx_if.rx_cg_invalid), 32'd0);
        step(D16_2_RDP, 1'b1);
        chk("as1_even", 32'(rx_if.rx_even), 32'd0);
        step(D16_2_RDN, 1'b1);
        chk("as1_even2", 32'(rx_if.rx_even), 32'd1);
        step(K28_5_RDP, 1'b1);
        chk("oddk_sync", 32'(rx_if.sync_status), 32'd0);
        chk("oddk_even", 32'(rx_if.rx_even), 32'd0);
        step(D16_2_RDP, 1'b1);
        chk("los_even", 32'(rx_if.rx_even), 32'd1);
        acquire("acq1");
        step(K28_5_RDP, 1'b1);
        chk("sa1_k_even", 32'(rx_if.rx_even), 32'd1);
        chk("sa1_k_sync", 32'(rx_if.sync_status), 32'd1);
        step(D16_2_RDN, 1'b1);
        chk("sa1_d_even", 32'(rx_if.rx_even), 32'd0);

        // One bad group then four good groups: sync held, invalid pulses once
        step(K28_5_RDN, 1'b1);
        step(BAD, 1'b1);
        chk("bad1_sync", 32'(rx_if.sync_status), 32'd1);
        chk("bad1_inv", 32'(rx_if.rx_cg_invalid), 32'd1);
        chk("bad1_cgo", 32'(rx_if.rx_code_group_o), 32'd0);
        step(K28_5_RDN, 1'b1);
        chk("rec1_inv", 32'(rx_if.rx_cg_invalid), 32'd0);
        chk("rec1_sync", 32'(rx_if.sync_status), 32'd1);
        step(D16_2_RDP, 1'b1);
        step(K28_5_RDP, 1'b1);
        step(D16_2_RDN, 1'b1);
        chk("rec4_sync", 32'(rx_if.sync_status), 32'd1);
        chk("rec4_even", 32'(rx_if.rx_even), 32'd0);

        // Run of bad groups walks SA2..SA4 down to LOS
        step(BAD, 1'b1);
        chk("run1_sync", 32'(rx_if.sync_status), 32'd1);
        step(BAD, 1'b1);
        chk("run2_sync", 32'(rx_if.sync_status), 32'd1);
        step(BAD, 1'b1);
        chk("run3_inv", 32'(rx_if.rx_cg_invalid), 32'd1);
        step(BAD, 1'b1);
        chk("run4_sync", 32'(rx_if.sync_status), 32'd0);
        acquire("acq2");

        // Loss of signal for one cycle forces LOS even with a comma present
        step(K28_5_RDN, 1'b0);
        chk("sd0_sync", 32'(rx_if.sync_status), 32'd0);
        step(D16_2_RDP, 1'b1);
        chk("sd1_nocomma_sync", 32'(rx_if.sync_status), 32'd0);
        acquire("acq3");

        // Reach SA3A, then reset asynchronously in the middle of a cycle
        step(BAD, 1'b1);
        step(BAD, 1'b1);
        step(D16_2_RDP, 1'b1);
        chk("sa3a_sync", 32'(rx_if.sync_status), 32'd1);
        chk("sa3a_cgo", 32'(rx_if.rx_code_group_o), 32'(D16_2_RDP));
        #2;
        mr_main_reset = 1'b1;
        #1;
        chk("arst_sync", 32'(rx_if.sync_status), 32'd0);
        chk("arst_even", 32'(rx_if.rx_even), 32'd0);
        chk("arst_cgo", 32'(rx_if.rx_code_group_o), 32'd0);
        chk("arst_inv", 32'(rx_if.rx_cg_invalid), 32'd0);
        @(posedge gtx_clk);
        #1;
        mr_main_reset = 1'b0;
        acquire("acq4");

        // Classifier corner cases, observed through the delayed outputs
        vec_cg[0] = 10'b1010101010; vec_inv[0] = 1'b0;  // D21.5
        vec_cg[1] = 10'b1000110111; vec_inv[1] = 1'b0;  // D17.7 RD- uses A7
        vec_cg[2] = 10'b1000111110; vec_inv[2] = 1'b1;  // P7 where A7 is required
        vec_cg[3] = 10'b0011111000; vec_inv[3] = 1'b0;  // K28.7 RD-
        vec_cg[4] = 10'b1111111111; vec_inv[4] = 1'b1;
        vec_cg[5] = 10'b0001010111; vec_inv[5] = 1'b0;  // K23.7 RD+
        vec_cg[6] = 10'b1110101110; vec_inv[6] = 1'b1;  // D23 6b with P7 on wrong column
        for (int i = 0; i < 7; i++) begin
            step(vec_cg[i], 1'b0);
            chk($sformatf("cls%0d_inv", i), 32'(rx_if.rx_cg_invalid), 32'(vec_inv[i]));
            chk($sformatf("cls%0d_cgo", i), 32'(rx_if.rx_code_group_o), 32'(vec_cg[i]));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
